// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and defaults for the input debouncer
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  // A single-cycle qualifier still needs a one-bit counter to hold its terminal value.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - parameterised flop chain bringing an asynchronous bit into the clk domain
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - synchronises and debounces one raw input, with rise/fall strobes
module input_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic a_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          s_in;
  db_state_t     state;
  logic [CW-1:0] cnt;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (raw_in),
    .q    (s_in)
  );

  // Outputs are assigned alongside each transition so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= LOW;
      cnt   <= '0;
      a_out <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        LOW: begin
          if (s_in) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (!s_in) begin
            state <= LOW;
            busy  <= 1'b0;
          end else if (cnt == TERM) begin
            state <= HIGH;
            busy  <= 1'b0;
            a_out <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!s_in) begin
            state <= WAIT_LOW;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (s_in) begin
            state <= HIGH;
            busy  <= 1'b0;
          end else if (cnt == TERM) begin
            state <= LOW;
            busy  <= 1'b0;
            a_out <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
          a_out <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
